// File: rtl/z80_wait_gen.sv
// ---------------------------------------------------------------------------
// z80_wait_gen
//
// Purpose:
//   WAIT-state generator for a Z80 bus. Each CPU bus cycle is classified as
//   an interrupt acknowledge, an I/O access or a memory access. ROM and RAM
//   are told apart by address. The cycle is then stretched by a per-class
//   number of wait ticks by pulling wait_n low. The number of wait ticks
//   inserted since reset is counted in a saturating 16-bit counter.
//
// Optional feature:
//   Define Z80_WAIT_GEN_EXTWAIT_EN to add the input ext_wait_n. It is ANDed
//   combinationally into wait_n so that an external agent can also stretch
//   cycles. It has no effect on the FSM or on wait_total.
//
// Ports:
//   clk         master clock; all state changes on its rising edge
//   reset       synchronous, active-high reset
//   cen         CPU clock enable; the FSM and counters advance only when high
//   mreq_n      memory request strobe (active low)
//   iorq_n      I/O request strobe (active low)
//   rd_n        read strobe (active low)
//   wr_n        write strobe (active low)
//   m1_n        opcode fetch / interrupt acknowledge marker (active low)
//   rfsh_n      refresh marker (active low)
//   busak_n     bus acknowledge (active low); while low, the block is idle
//   A[15:0]     CPU address bus
//   ext_wait_n  external WAIT request (only with Z80_WAIT_GEN_EXTWAIT_EN)
//   wait_n      WAIT to the CPU; low stretches the current cycle
//   busy        high whenever the FSM is not IDLE
//   wait_total  saturating count of wait ticks inserted since reset
// ---------------------------------------------------------------------------
module z80_wait_gen #(
  parameter logic [15:0] ROM_TOP   = 16'h3FFF,
  parameter logic [3:0]  ROM_WAIT  = 4'd1,
  parameter logic [3:0]  RAM_WAIT  = 4'd0,
  parameter logic [3:0]  IO_WAIT   = 4'd1,
  parameter logic [3:0]  INTA_WAIT = 4'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cen,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  input  logic        busak_n,
  input  logic [15:0] A,
`ifdef Z80_WAIT_GEN_EXTWAIT_EN
  input  logic        ext_wait_n,
`endif
  output logic        wait_n,
  output logic        busy,
  output logic [15:0] wait_total
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_wait_n;
  logic        w_wait_n_nxt;
  logic [15:0] r_total;
  logic [15:0] w_total_nxt;

  logic        w_rw;
  logic        w_inta;
  logic        w_io;
  logic        w_mem;
  logic        w_is_rom;
  logic        w_start;
  logic        w_bus_idle;
  logic [3:0]  w_n;

  // Saturating increment: the total sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // Cycle classification. A memory access is only recognised while iorq_n
  // is high, so a cycle with both requests low is never counted as memory.
  // Refresh cycles (rfsh_n low) never start a stretch.
  assign w_rw       = ~rd_n | ~wr_n;
  assign w_inta     = ~iorq_n & ~m1_n;
  assign w_io       = ~iorq_n &  m1_n & w_rw;
  assign w_mem      = ~mreq_n &  iorq_n & rfsh_n & w_rw;
  assign w_is_rom   = (A <= ROM_TOP);
  assign w_start    = w_inta | w_io | w_mem;
  assign w_bus_idle = mreq_n & iorq_n & rd_n & wr_n;

  always_comb begin
    w_n = RAM_WAIT;
    if (w_inta) begin
      w_n = INTA_WAIT;
    end else if (w_io) begin
      w_n = IO_WAIT;
    end else if (w_is_rom) begin
      w_n = ROM_WAIT;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_wait_n_nxt = r_wait_n;
    w_total_nxt  = r_total;

    if (!busak_n) begin
      // The bus has been granted away: drop any stretch immediately,
      // whether or not this is a CPU tick.
      w_state_nxt  = IDLE;
      w_cnt_nxt    = 4'd0;
      w_wait_n_nxt = 1'b1;
    end else if (cen) begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            if (w_n != 4'd0) begin
              // WAIT is asserted on the same edge that the cycle is seen.
              w_cnt_nxt    = w_n;
              w_wait_n_nxt = 1'b0;
              w_state_nxt  = STALL;
            end else begin
              w_state_nxt  = HOLD;
            end
          end
        end

        STALL: begin
          if (w_bus_idle) begin
            // CPU abandoned the cycle; release WAIT without counting a tick.
            w_cnt_nxt    = 4'd0;
            w_wait_n_nxt = 1'b1;
            w_state_nxt  = IDLE;
          end else begin
            w_cnt_nxt   = r_cnt - 4'd1;
            w_total_nxt = sat_inc(r_total);
            if (r_cnt <= 4'd1) begin
              w_cnt_nxt    = 4'd0;
              w_wait_n_nxt = 1'b1;
              w_state_nxt  = HOLD;
            end
          end
        end

        HOLD: begin
          // Wait for the strobes to release so one bus cycle is only
          // stretched once.
          if (w_bus_idle) begin
            w_state_nxt = IDLE;
          end
        end

        default: begin
          w_state_nxt  = IDLE;
          w_cnt_nxt    = 4'd0;
          w_wait_n_nxt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_wait_n <= 1'b1;
      r_total  <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wait_n <= w_wait_n_nxt;
      r_total  <= w_total_nxt;
    end
  end

`ifdef Z80_WAIT_GEN_EXTWAIT_EN
  assign wait_n = r_wait_n & ext_wait_n;
`else
  assign wait_n = r_wait_n;
`endif

  assign busy       = (r_state != IDLE);
  assign wait_total = r_total;

endmodule

// File: tb/tb_z80_wait_gen.sv
module tb_z80_wait_gen;

  localparam int K_MRD  = 0;
  localparam int K_MWR  = 1;
  localparam int K_IORD = 2;
  localparam int K_IOWR = 3;
  localparam int K_INTA = 4;
  localparam int K_MIX  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        reset, cen, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, busak_n;
  logic [15:0] A;
  logic        wait_n, busy;
  logic [15:0] wait_total;
`ifdef Z80_WAIT_GEN_EXTWAIT_EN
  logic        ext_wait_n;
`endif

  // Saturation instance (ROM_WAIT = 15 to reach 16'hFFFF quickly)
  logic        s_reset, s_cen, s_mreq_n, s_iorq_n, s_rd_n, s_wr_n, s_m1_n, s_rfsh_n, s_busak_n;
  logic [15:0] s_A;
  logic        s_wait_n, s_busy;
  logic [15:0] s_total;

  z80_wait_gen dut (
    .clk        (clk),
    .reset      (reset),
    .cen        (cen),
    .mreq_n     (mreq_n),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .m1_n       (m1_n),
    .rfsh_n     (rfsh_n),
    .busak_n    (busak_n),
    .A          (A),
`ifdef Z80_WAIT_GEN_EXTWAIT_EN
    .ext_wait_n (ext_wait_n),
`endif
    .wait_n     (wait_n),
    .busy       (busy),
    .wait_total (wait_total)
  );

  z80_wait_gen #(.ROM_WAIT(4'd15)) dut_s (
    .clk        (clk),
    .reset      (s_reset),
    .cen        (s_cen),
    .mreq_n     (s_mreq_n),
    .iorq_n     (s_iorq_n),
    .rd_n       (s_rd_n),
    .wr_n       (s_wr_n),
    .m1_n       (s_m1_n),
    .rfsh_n     (s_rfsh_n),
    .busak_n    (s_busak_n),
    .A          (s_A),
`ifdef Z80_WAIT_GEN_EXTWAIT_EN
    .ext_wait_n (1'b1),
`endif
    .wait_n     (s_wait_n),
    .busy       (s_busy),
    .wait_total (s_total)
  );

  typedef struct {
    string nm;
    int    low;
    int    tot;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   div   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (div == 1) cen = 1'b1;
    else if (div == 2) cen = ~cen;
  endtask

  task automatic s_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    m1_n   = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic expect_cyc(input string nm, input int low, input int tot);
    exp_t e;
    e.nm = nm; e.low = low; e.tot = tot;
    sb.push_back(e);
  endtask

  task automatic drive_kind(input int kind, input logic [15:0] addr);
    A = addr;
    case (kind)
      K_MRD:  begin mreq_n = 1'b0; rd_n = 1'b0; end
      K_MWR:  begin mreq_n = 1'b0; wr_n = 1'b0; end
      K_IORD: begin iorq_n = 1'b0; rd_n = 1'b0; end
      K_IOWR: begin iorq_n = 1'b0; wr_n = 1'b0; end
      K_INTA: begin iorq_n = 1'b0; m1_n = 1'b0; end
      default: begin mreq_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0; end
    endcase
  endtask

  // One complete bus cycle: strobes held for 'hold' clocks, then released.
  task automatic bus(input string nm, input int kind, input logic [15:0] addr,
                     input int hold, input int low, input int tot);
    expect_cyc(nm, low, tot);
    drive_kind(kind, addr);
    repeat (hold) cyc();
    check({nm, "_busy_in_hold"}, {31'd0, busy}, 32'd1);
    check({nm, "_wait_released"}, {31'd0, wait_n}, 32'd1);
    idle_bus();
    repeat (3) cyc();
  endtask

  // Monitor: measures how many clocks wait_n was low during each busy
  // period, and compares against the scoreboard when busy drops.
  initial begin : monitor
    bit   prev_busy;
    int   lowclk;
    exp_t e;
    prev_busy = 1'b0;
    lowclk    = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && !prev_busy) lowclk = (wait_n === 1'b0) ? 1 : 0;
      else if (busy === 1'b1 && wait_n === 1'b0) lowclk++;
      if (busy === 1'b0 && prev_busy) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_cycle: busy period with %0d wait clocks, none required (t=%0t)", lowclk, $time);
        end else begin
          e = sb.pop_front();
          check({e.nm, "_wait_clocks"}, lowclk, e.low);
          check({e.nm, "_wait_total"}, {16'd0, wait_total}, e.tot);
        end
      end
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin : watchdog
    #1500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : stim
    idle_bus();
    A = 16'h0000; busak_n = 1'b1; reset = 1'b1; cen = 1'b0; div = 0;
`ifdef Z80_WAIT_GEN_EXTWAIT_EN
    ext_wait_n = 1'b1;
`endif
    s_reset = 1'b1; s_cen = 1'b1; s_mreq_n = 1'b1; s_iorq_n = 1'b1; s_rd_n = 1'b1;
    s_wr_n = 1'b1; s_m1_n = 1'b1; s_rfsh_n = 1'b1; s_busak_n = 1'b1; s_A = 16'h0100;

    // Reset applied with cen low must still initialise everything
    repeat (3) cyc();
    check("rst_wait_n", {31'd0, wait_n}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_total", {16'd0, wait_total}, 32'd0);
    reset = 1'b0; s_reset = 1'b0; cen = 1'b1; div = 1;

    fork
      begin : main_seq
        bus("rom_rd_0100", K_MRD, 16'h0100, 4, 1, 1);

        div = 2;
        bus("io_wr_0010_cen2", K_IOWR, 16'h0010, 6, 2, 2);
        div = 1;

        bus("inta", K_INTA, 16'h0000, 5, 2, 4);

        // Refresh with a read strobe low: never decoded, never stretched
        A = 16'h0100; mreq_n = 1'b0; rd_n = 1'b0; rfsh_n = 1'b0;
        repeat (4) cyc();
        check("rfsh_busy", {31'd0, busy}, 32'd0);
        check("rfsh_total", {16'd0, wait_total}, 32'd4);
        idle_bus();
        repeat (2) cyc();

        bus("ram_rd_8000", K_MRD, 16'h8000, 3, 0, 4);
        bus("rom_wr_3fff", K_MWR, 16'h3FFF, 4, 1, 5);
        bus("ram_rd_4000", K_MRD, 16'h4000, 3, 0, 5);
        bus("mreq_iorq_both", K_MIX, 16'h8000, 4, 1, 6);

        // N latched at start: INTA (2) morphs into an I/O read to RAM
        expect_cyc("inta_latched_n", 2, 8);
        drive_kind(K_INTA, 16'h0000);
        cyc();
        m1_n = 1'b1; rd_n = 1'b0; A = 16'h8000;
        repeat (4) cyc();
        idle_bus();
        repeat (3) cyc();

        // cen low for 5 clocks mid-stall: everything holds
        div = 0; cen = 1'b1;
        expect_cyc("inta_cen_hold", 7, 10);
        drive_kind(K_INTA, 16'h0000);
        cyc();
        cen = 1'b0;
        repeat (5) cyc();
        cen = 1'b1;
        repeat (4) cyc();
        idle_bus();
        repeat (3) cyc();
        div = 1;

        // Aborted cycle: strobes released during stall, tick not counted
        expect_cyc("inta_abort", 1, 10);
        drive_kind(K_INTA, 16'h0000);
        cyc();
        idle_bus();
        repeat (3) cyc();

        // busak_n low mid-stall with cen low
        div = 0; cen = 1'b1;
        expect_cyc("busak_stall", 1, 10);
        drive_kind(K_INTA, 16'h0000);
        cyc();
        busak_n = 1'b0; cen = 1'b0;
        cyc();
        check("busak_wait_n", {31'd0, wait_n}, 32'd1);
        check("busak_busy", {31'd0, busy}, 32'd0);
        cen = 1'b1;
        repeat (3) cyc();
        check("busak_no_decode", {31'd0, busy}, 32'd0);
        idle_bus();
        cyc();
        busak_n = 1'b1;
        repeat (2) cyc();

        // Reset mid-stall with cen low, then first decode right after reset
        expect_cyc("reset_stall", 1, 0);
        drive_kind(K_INTA, 16'h0000);
        cyc();
        reset = 1'b1; cen = 1'b0;
        cyc();
        check("rststall_wait_n", {31'd0, wait_n}, 32'd1);
        check("rststall_busy", {31'd0, busy}, 32'd0);
        check("rststall_total", {16'd0, wait_total}, 32'd0);
        idle_bus();
        drive_kind(K_MRD, 16'h0100);
        cen = 1'b1;
        repeat (2) cyc();
        check("rst_held_no_decode", {31'd0, busy}, 32'd0);
        expect_cyc("post_reset_rom", 1, 1);
        reset = 1'b0;
        cyc();
        check("post_reset_wait_low", {31'd0, wait_n}, 32'd0);
        check("post_reset_busy", {31'd0, busy}, 32'd1);
        repeat (3) cyc();
        idle_bus();
        repeat (3) cyc();
        div = 1;

`ifdef Z80_WAIT_GEN_EXTWAIT_EN
        ext_wait_n = 1'b0;
        #1;
        check("ext_wait_low", {31'd0, wait_n}, 32'd0);
        check("ext_busy", {31'd0, busy}, 32'd0);
        repeat (3) cyc();
        check("ext_total", {16'd0, wait_total}, 32'd1);
        ext_wait_n = 1'b1;
        #1;
        check("ext_wait_release", {31'd0, wait_n}, 32'd1);
`endif
        repeat (2) cyc();
      end

      begin : sat_seq
        // 4369 ROM cycles of 15 ticks = 65535 ticks
        for (int i = 0; i < 4369; i++) begin
          s_mreq_n = 1'b0; s_rd_n = 1'b0;
          repeat (16) s_tick();
          s_mreq_n = 1'b1; s_rd_n = 1'b1;
          s_tick();
          if (i == 4367) check("sat_before_last", {16'd0, s_total}, 32'd65520);
        end
        check("sat_reached", {16'd0, s_total}, 32'h0000FFFF);
        s_mreq_n = 1'b0; s_rd_n = 1'b0;
        s_tick();
        check("sat_extra_wait_low", {31'd0, s_wait_n}, 32'd0);
        repeat (15) s_tick();
        s_mreq_n = 1'b1; s_rd_n = 1'b1;
        s_tick();
        check("sat_no_wrap", {16'd0, s_total}, 32'h0000FFFF);
        check("sat_idle", {31'd0, s_busy}, 32'd0);
      end
    join

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/z80_wait_gen.md
Z80_WAIT_GEN -- requirements
Module: z80_wait_gen

Interface
REQ-001 Parameter ROM_TOP, 16'h3FFF, highest address of ROM region; memory addresses at or below it are ROM, above are RAM.
REQ-002 Parameter ROM_WAIT, 1, wait ticks inserted per ROM read/write (0-15).
REQ-003 Parameter RAM_WAIT, 0, wait ticks inserted per RAM read/write (0-15).
REQ-004 Parameter IO_WAIT, 1, wait ticks inserted per I/O read/write (0-15).
REQ-005 Parameter INTA_WAIT, 2, wait ticks inserted per interrupt acknowledge (0-15).
REQ-006 clk  input  1  master clock; one clock; all state on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 cen  input  1  CPU clock enable; the FSM and counter advance only when high.
REQ-009 mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, busak_n  input  1 each  CPU bus strobes (active low).
REQ-010 A  input  16  CPU address bus.
REQ-011 wait_n  output  1  registered WAIT to the CPU, low = stretch cycle.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.
REQ-013 wait_total  output  16  saturating count of wait ticks inserted since reset.

Function
REQ-014 Cycle classes are decoded each cen tick:
- INTA: iorq_n=0 & m1_n=0
- IO: iorq_n=0 & m1_n=1 & (rd_n=0 | wr_n=0)
- MEM: mreq_n=0 & rfsh_n=1 & (rd_n=0 | wr_n=0)
REQ-015 If iorq_n and mreq_n are both low, the cycle SHALL be classified INTA or IO, never MEM.
REQ-016 Refresh cycles (rfsh_n=0) SHALL never insert waits.
REQ-017 FSM states SHALL be IDLE, STALL and HOLD.
REQ-018 IDLE, cen=1, class decoded with N>0: load counter with N, drive wait_n=0 on the same edge, go to STALL.
REQ-019 IDLE, cen=1, class decoded with N=0: go directly to HOLD; wait_n stays 1.
REQ-020 STALL, each cen tick: decrement counter and increment wait_total; when counter reaches 0, set wait_n=1 and go to HOLD.
REQ-021 Latency: wait_n stays low for exactly N cen ticks.
REQ-022 HOLD: stay until all of mreq_n, iorq_n, rd_n and wr_n are high on a cen tick, then go to IDLE, so each bus cycle is stretched at most once.
REQ-023 N SHALL be latched at cycle start; address or strobe changes during STALL SHALL NOT alter N.
REQ-024 STALL with all strobes inactive (aborted cycle): set wait_n=1 and go to IDLE on that cen tick.
REQ-025 busak_n=0 on any clk: force IDLE and wait_n=1 regardless of cen; no decode while busak_n=0.
REQ-026 cen=0: state, counter, wait_n and wait_total SHALL hold.
REQ-027 wait_total SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-028 ROM/RAM compare SHALL be unsigned: A <= ROM_TOP is ROM.

Reset
REQ-029 While reset=1 at a clk edge, regardless of cen, the block SHALL load: state=IDLE, counter=0, wait_n=1, busy=0, wait_total=0.
REQ-030 Reset asserted mid-STALL SHALL release wait_n on that edge.
REQ-031 After reset the first decode SHALL occur on the first cen tick with reset=0.

Configuration
REQ-032 Macro Z80_WAIT_GEN_EXTWAIT_EN defined: add input ext_wait_n (1 bit, active low) and drive wait_n = internal wait & ext_wait_n combinationally; ext_wait_n does not affect the FSM or wait_total.
REQ-033 Macro absent: no ext_wait_n port; wait_n is the registered FSM output only.

Verification
REQ-034 ROM read at A=16'h0100, defaults -> wait_n low exactly 1 cen tick, wait_total=1.
REQ-035 IO write at A=16'h0010 with cen toggling every 2nd clk -> wait_n low for 1 cen tick (2 clk), busy high until wr_n/iorq_n release.
REQ-036 INTA cycle (iorq_n=0, m1_n=0), then refresh mreq_n=0 with rfsh_n=0 -> exactly 2 wait ticks for INTA, none for refresh.
REQ-037 RAM read at A=16'h8000, RAM_WAIT=0 -> wait_n never low, busy high for cycle duration, wait_total unchanged.
REQ-038 busak_n or reset pulled low/high mid-STALL with INTA_WAIT=15 -> wait_n=1 on the next edge, FSM in IDLE.
REQ-039 Preload via 65535 ROM cycles, then one more -> wait_total stays 16'hFFFF; with Z80_WAIT_GEN_EXTWAIT_EN, ext_wait_n=0 in IDLE -> wait_n=0, wait_total unchanged.
